// File: rtl/vga_pkg.sv
// Shared VGA timing constants plus background scene phase and palette types.
package vga_pkg;

  localparam logic [10:0] HOR_PIXELS = 11'd1024;

  typedef enum logic [1:0] {
    DAY   = 2'd0,
    DUSK  = 2'd1,
    NIGHT = 2'd2,
    DAWN  = 2'd3
  } phase_t;

  // Index 0 is DAY, index 3 is DAWN.
  localparam logic [3:0][11:0] SKY_PAL = {
    12'hF8C, 12'h002, 12'hF60, 12'h00F
  };
  localparam logic [3:0][11:0] GROUND_PAL = {
    12'h0A0, 12'h020, 12'h080, 12'h0F0
  };

  function automatic phase_t next_phase(
    input phase_t p
  );
    return phase_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/bg_scene_ctrl_if.sv
// Valid/ready configuration port used by game logic to retune the scene.
interface bg_cfg_if;
  import vga_pkg::*;

  logic       valid;
  logic       ready;
  logic [3:0] speed;
  logic       auto_en;
  phase_t     phase;

  modport master (
    output valid, speed, auto_en, phase,
    input  ready
  );
  modport slave (
    input  valid, speed, auto_en, phase,
    output ready
  );
endinterface

// File: rtl/vga_if.sv
// Timing bus from the timing generator to the background stage.
interface vga_if;
  logic vblnk;

  modport out (output vblnk);
  modport in  (input  vblnk);
endinterface

// File: rtl/bg_scene_ctrl_edge.sv
// Rising-edge detector on vblnk; reset state 1 suppresses a tick at release.
module vblnk_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic vblnk_i,
  output logic b_o
);

  logic vblnk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q <= 1'b1;
    end else begin
      vblnk_q <= vblnk_i;
    end
  end

  assign b_o = vblnk_i & ~vblnk_q;

endmodule

// File: rtl/bg_scene_ctrl.sv
// Frame-synchronous scroll, phase and palette controller for the background.
module bg_scene_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned PHASE_FRAMES = 600,
  parameter logic [3:0]  DEF_SPEED    = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  vga_if.in           vga_in,
  bg_cfg_if.slave     cfg,
  output logic        frame_tick,
  output logic [10:0] cloud_xoff,
  output phase_t      phase,
  output logic [11:0] sky_rgb,
  output logic [11:0] ground_rgb,
  output logic [15:0] frame_cnt
);

  localparam int unsigned PCW =
    (PHASE_FRAMES > 1) ? $clog2(PHASE_FRAMES) : 1;
  localparam logic [PCW-1:0] PC_LAST = PCW'(PHASE_FRAMES - 1);

  logic           bnd;
  logic           tick_q, tick_d;
  logic [10:0]    xoff_q, xoff_d, xsum;
  logic [15:0]    fcnt_q, fcnt_d;
  phase_t         phase_q, phase_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic [3:0]     speed_q, speed_d;
  logic           auto_q, auto_d;
  logic           ready_q, ready_d;
  logic [3:0]     pspeed_q, pspeed_d;
  logic           pauto_q, pauto_d;
  phase_t         pphase_q, pphase_d;
  logic [11:0]    sky_q, sky_d;
  logic [11:0]    gnd_q, gnd_d;

  vblnk_edge_det u_edge (
    .clk     (clk),
    .rst     (rst),
    .vblnk_i (vga_in.vblnk),
    .b_o     (bnd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q   <= 1'b0;
      xoff_q   <= '0;
      fcnt_q   <= '0;
      phase_q  <= DAY;
      pcnt_q   <= '0;
      speed_q  <= DEF_SPEED;
      auto_q   <= 1'b1;
      ready_q  <= 1'b1;
      pspeed_q <= '0;
      pauto_q  <= 1'b0;
      pphase_q <= DAY;
      sky_q    <= SKY_PAL[DAY];
      gnd_q    <= GROUND_PAL[DAY];
    end else begin
      tick_q   <= tick_d;
      xoff_q   <= xoff_d;
      fcnt_q   <= fcnt_d;
      phase_q  <= phase_d;
      pcnt_q   <= pcnt_d;
      speed_q  <= speed_d;
      auto_q   <= auto_d;
      ready_q  <= ready_d;
      pspeed_q <= pspeed_d;
      pauto_q  <= pauto_d;
      pphase_q <= pphase_d;
      sky_q    <= sky_d;
      gnd_q    <= gnd_d;
    end
  end

  always_comb begin
    tick_d   = 1'b0;
    xoff_d   = xoff_q;
    fcnt_d   = fcnt_q;
    phase_d  = phase_q;
    pcnt_d   = pcnt_q;
    speed_d  = speed_q;
    auto_d   = auto_q;
    ready_d  = ready_q;
    pspeed_d = pspeed_q;
    pauto_d  = pauto_q;
    pphase_d = pphase_q;
    xsum     = xoff_q + {7'd0, speed_q};

    // A word taken on a boundary edge waits for the next boundary.
    if (cfg.valid && ready_q) begin
      pspeed_d = cfg.speed;
      pauto_d  = cfg.auto_en;
      pphase_d = cfg.phase;
      ready_d  = 1'b0;
    end

    if (bnd) begin
      tick_d = 1'b1;
      xoff_d = (xsum >= HOR_PIXELS) ? xsum - HOR_PIXELS : xsum;
      fcnt_d = fcnt_q + 16'd1;
      if (!ready_q) begin
        speed_d = pspeed_q;
        auto_d  = pauto_q;
        phase_d = pphase_q;
        pcnt_d  = '0;
        ready_d = 1'b1;
      end else if (auto_q) begin
        if (pcnt_q == PC_LAST) begin
          phase_d = next_phase(phase_q);
          pcnt_d  = '0;
        end else begin
          pcnt_d = pcnt_q + PCW'(1);
        end
      end else begin
        pcnt_d = '0;
      end
    end

    sky_d = SKY_PAL[phase_d];
    gnd_d = GROUND_PAL[phase_d];
  end

  assign cfg.ready  = ready_q;
  assign frame_tick = tick_q;
  assign cloud_xoff = xoff_q;
  assign phase      = phase_q;
  assign sky_rgb    = sky_q;
  assign ground_rgb = gnd_q;
  assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_bg_scene_ctrl.sv
// Self-checking bench for bg_scene_ctrl: vector table, corner sequences, random run.
module tb_bg_scene_ctrl;
  import vga_pkg::*;

  localparam int PF   = 4;
  localparam int HORP = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic [10:0] cloud_xoff;
  phase_t      phase;
  logic [11:0] sky_rgb, ground_rgb;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  vga_if    vga ();
  bg_cfg_if cfg ();

  bg_scene_ctrl #(
    .PHASE_FRAMES (PF),
    .DEF_SPEED    (4'd1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vga_in     (vga),
    .cfg        (cfg),
    .frame_tick (frame_tick),
    .cloud_xoff (cloud_xoff),
    .phase      (phase),
    .sky_rgb    (sky_rgb),
    .ground_rgb (ground_rgb),
    .frame_cnt  (frame_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: per-frame arithmetic and a one-deep request queue.
  typedef struct {
    int spd;
    int aut;
    int ph;
  } cfg_t;

  cfg_t pend[$];
  int m_prev, m_tick, m_xoff, m_cnt, m_ph, m_inph, m_speed, m_auto;

  function automatic int sky_of(input int p);
    case (p)
      0:       return 'h00F;
      1:       return 'hF60;
      2:       return 'h002;
      default: return 'hF8C;
    endcase
  endfunction

  function automatic int gnd_of(input int p);
    case (p)
      0:       return 'h0F0;
      1:       return 'h080;
      2:       return 'h020;
      default: return 'h0A0;
    endcase
  endfunction

  task automatic model_edge();
    bit   had, acc, bnd;
    cfg_t c;
    if (rst) begin
      m_prev = 1; m_tick = 0; m_xoff = 0; m_cnt = 0;
      m_ph = 0; m_inph = 0; m_speed = 1; m_auto = 1;
      pend.delete();
      return;
    end
    had = (pend.size() > 0);
    acc = cfg.valid && !had;
    bnd = vga.vblnk && !m_prev;
    m_prev = vga.vblnk;
    m_tick = bnd;
    if (bnd) begin
      m_xoff = (m_xoff + m_speed) % HORP;
      m_cnt  = (m_cnt + 1) % 65536;
      if (had) begin
        c = pend.pop_front();
        m_speed = c.spd; m_auto = c.aut; m_ph = c.ph; m_inph = 0;
      end else if (m_auto != 0) begin
        m_inph++;
        if (m_inph == PF) begin
          m_inph = 0;
          m_ph = (m_ph + 1) % 4;
        end
      end else begin
        m_inph = 0;
      end
    end
    if (acc) pend.push_back('{int'(cfg.speed), int'(cfg.auto_en), int'(cfg.phase)});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("tick",   frame_tick,   m_tick);
    chk("xoff",   cloud_xoff,   m_xoff);
    chk("fcnt",   frame_cnt,    m_cnt);
    chk("phase",  int'(phase),  m_ph);
    chk("sky",    sky_rgb,      sky_of(m_ph));
    chk("ground", ground_rgb,   gnd_of(m_ph));
    chk("ready",  cfg.ready,    (pend.size() == 0) ? 1 : 0);
  endtask

  task automatic frame();
    vga.vblnk = 1'b0;
    repeat (3) step();
    vga.vblnk = 1'b1;
    repeat (2) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  typedef struct {
    bit r;
    bit v;
    int tick;
    int xoff;
    int cnt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    rst         = 1'b1;
    vga.vblnk   = 1'b1;
    cfg.valid   = 1'b0;
    cfg.speed   = 4'd0;
    cfg.auto_en = 1'b1;
    cfg.phase   = DAY;

    // Reset, release inside blanking, then three frame boundaries.
    tbl[0]  = '{1, 1, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 1, 1, 1};
    tbl[6]  = '{0, 1, 0, 1, 1};
    tbl[7]  = '{0, 0, 0, 1, 1};
    tbl[8]  = '{0, 1, 1, 2, 2};
    tbl[9]  = '{0, 0, 0, 2, 2};
    tbl[10] = '{0, 1, 1, 3, 3};
    tbl[11] = '{0, 1, 0, 3, 3};
    for (int i = 0; i < 12; i++) begin
      rst       = tbl[i].r;
      vga.vblnk = tbl[i].v;
      step();
      chk("tbl_tick", frame_tick, tbl[i].tick);
      chk("tbl_xoff", cloud_xoff, tbl[i].xoff);
      chk("tbl_fcnt", frame_cnt,  tbl[i].cnt);
    end
    rst = 1'b0;
    chk("tbl_phase", int'(phase), 0);
    chk("tbl_sky",   sky_rgb,     'h00F);

    // Speed 3, auto off, taken mid-frame; then a full wrap of the offset.
    vga.vblnk = 1'b1;
    do_reset();
    vga.vblnk = 1'b0;
    repeat (2) step();
    cfg.valid = 1'b1; cfg.speed = 4'd3; cfg.auto_en = 1'b0; cfg.phase = DAY;
    step();
    cfg.valid = 1'b0;
    chk("a_ready_low", cfg.ready, 0);
    frame();
    chk("a_first_xoff", cloud_xoff, 1);
    chk("a_ready_high", cfg.ready, 1);
    repeat (342) frame();
    chk("a_wrap_xoff", cloud_xoff, 3);
    chk("a_held_phase", int'(phase), 0);

    // Auto-advance through all four phases.
    vga.vblnk = 1'b1;
    do_reset();
    for (int f = 1; f <= 16; f++) begin
      frame();
      if (f == 3)  chk("b_day3", int'(phase), 0);
      if (f == 4)  chk("b_dusk", int'(phase), 1);
      if (f == 8)  chk("b_night", int'(phase), 2);
      if (f == 8)  chk("b_night_sky", sky_rgb, 'h002);
      if (f == 8)  chk("b_night_gnd", ground_rgb, 'h020);
      if (f == 12) chk("b_dawn", int'(phase), 3);
      if (f == 16) chk("b_day", int'(phase), 0);
    end

    // Request on the exact boundary edge waits one frame.
    vga.vblnk = 1'b1;
    do_reset();
    vga.vblnk = 1'b0;
    repeat (3) step();
    vga.vblnk = 1'b1;
    cfg.valid = 1'b1; cfg.speed = 4'd1; cfg.auto_en = 1'b1; cfg.phase = NIGHT;
    step();
    cfg.valid = 1'b0;
    chk("c_tick", frame_tick, 1);
    chk("c_not_yet", int'(phase), 0);
    chk("c_ready", cfg.ready, 0);
    step();
    frame();
    chk("c_applied", int'(phase), 2);
    repeat (3) frame();
    chk("c_cnt_cleared", int'(phase), 2);
    frame();
    chk("c_advance", int'(phase), 3);

    // Reset inside blanking drops a pending request and any tick.
    vga.vblnk = 1'b1;
    do_reset();
    vga.vblnk = 1'b0;
    step();
    cfg.valid = 1'b1; cfg.speed = 4'd7; cfg.auto_en = 1'b0; cfg.phase = DAWN;
    step();
    cfg.valid = 1'b0;
    chk("d_pending", cfg.ready, 0);
    rst = 1'b1; vga.vblnk = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();
    chk("d_no_tick", frame_tick, 0);
    chk("d_ready", cfg.ready, 1);
    frame();
    chk("d_xoff", cloud_xoff, 1);
    chk("d_phase", int'(phase), 0);

    // Held valid with changing data: only the first word is used.
    vga.vblnk = 1'b1;
    do_reset();
    vga.vblnk = 1'b0;
    step();
    cfg.valid = 1'b1; cfg.speed = 4'd5; cfg.auto_en = 1'b0; cfg.phase = DUSK;
    step();
    cfg.speed = 4'd9; cfg.auto_en = 1'b1; cfg.phase = DAWN;
    repeat (2) step();
    vga.vblnk = 1'b1;
    step();
    cfg.valid = 1'b0;
    chk("e_phase", int'(phase), 1);
    step();
    frame();
    chk("e_xoff", cloud_xoff, 6);
    chk("e_auto_off", int'(phase), 1);

    // Random traffic against the model.
    vga.vblnk = 1'b1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) vga.vblnk = ~vga.vblnk;
      cfg.valid   = ($urandom_range(0, 5) == 0);
      cfg.speed   = 4'($urandom_range(0, 15));
      cfg.auto_en = 1'($urandom_range(0, 3) != 0);
      cfg.phase   = phase_t'($urandom_range(0, 3));
      rst         = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
